sorter_8_sched: RTL

Stream-side controller for the 8-wide pipelined pair sorter (`sorter_8`). Accepts a valid/ready stream of tuple pairs and packs them into 8-pair blocks, padding a short final block with sentinels. Issues each block to the sorter under credit control, since the sorter has no backpressure, and buffers the sorted results. Unpacks results back to a valid/ready stream with the padding removed; sits between the AOC5 input loader and the range-merge stage.

---
 rtl/aoc5_pkg.sv | 36 +++
 rtl/sorter_8_sched_fifo.sv | 64 ++++++
 rtl/sorter_8_sched.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/aoc5_pkg.sv
// Shared types for the AOC5 sort path: tuple pairs, pad values, slot counts,
// packer states and the flat-array slot accessor.
package aoc5_pkg;

  localparam int DATA_WIDTH       = 16;
  localparam int PAIR_WIDTH       = 2 * DATA_WIDTH;
  localparam int ARR_8_FLAT_WIDTH = 8 * PAIR_WIDTH;
  localparam int META_WIDTH       = 5;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] first;
    logic [DATA_WIDTH-1:0] second;
  } tuple_pair_t;

  localparam tuple_pair_t PAD_ASC  = '1;
  localparam tuple_pair_t PAD_DESC = '0;

  typedef logic [3:0] slot_cnt_t;

  typedef enum logic {
    FILL  = 1'b0,
    ISSUE = 1'b1
  } pack_state_t;

  typedef struct packed {
    slot_cnt_t count;
    logic      last;
  } meta_t;

  // Slot 0 occupies the least-significant pair of the flat vector.
  function automatic tuple_pair_t index_flat(input logic [ARR_8_FLAT_WIDTH-1:0] flat,
                                             input logic [2:0] slot);
    return tuple_pair_t'(flat[slot*PAIR_WIDTH +: PAIR_WIDTH]);
  endfunction

endpackage

// File: rtl/sorter_8_sched_fifo.sv
// Parameterised block FIFO with full/empty flags and a combinational head
// read, so a pushed entry is visible the cycle after its push.
module sched_block_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sorter_8_sched.sv
// Stream-side controller for sorter_8: packs pairs into padded 8-slot blocks,
// issues them under credit, buffers results and unpacks the real slots.
// Optional statistics outputs are enabled with `define SORT_SCHED_STATS_EN.
module sorter_8_sched
  import aoc5_pkg::*;
#(
  parameter int RES_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PAIR_WIDTH-1:0]       in_pair,
  input  logic                        in_last,
  input  logic                        cfg_asc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PAIR_WIDTH-1:0]       out_pair,
  output logic                        out_last,
  output logic                        sort_valid_in,
  output logic                        sort_asc_in,
  output logic [ARR_8_FLAT_WIDTH-1:0] sort_pairs_in_flat,
  input  logic                        sort_valid_out,
  input  logic [ARR_8_FLAT_WIDTH-1:0] sort_pairs_out_flat,
  output logic                        err_overflow
`ifdef SORT_SCHED_STATS_EN
  ,
  output logic [31:0]                 stat_blocks,
  output logic [31:0]                 stat_pads
`endif
);

  localparam int IW = $clog2(RES_DEPTH + 1);
  localparam logic [IW-1:0] CREDITS = IW'(RES_DEPTH);

  pack_state_t                 state_q, state_d;
  slot_cnt_t                   idx_q, idx_d;
  logic                        asc_q, asc_d;
  logic                        last_q, last_d;
  tuple_pair_t                 block_q [8];
  tuple_pair_t                 block_d [8];
  logic                        sort_valid_q, sort_valid_d;
  logic                        sort_asc_q, sort_asc_d;
  logic [ARR_8_FLAT_WIDTH-1:0] sort_flat_q, sort_flat_d;
  logic [IW-1:0]               inflight_q, inflight_d;
  logic [2:0]                  slot_q, slot_d;
  logic                        err_q, err_d;

  logic                        issue;
  logic                        blk_pop;
  logic                        slot_final;
  logic                        res_full, res_empty, meta_full, meta_empty;
  logic [ARR_8_FLAT_WIDTH-1:0] res_head;
  logic [META_WIDTH-1:0]       meta_push_data, meta_pop_data;
  meta_t                       meta_head;

  assign in_ready           = (state_q == FILL) && !reset;
  assign sort_valid_in      = sort_valid_q;
  assign sort_asc_in        = sort_asc_q;
  assign sort_pairs_in_flat = sort_flat_q;
  assign err_overflow       = err_q;
  assign meta_push_data     = meta_t'{count: idx_q, last: last_q};
  assign meta_head          = meta_t'(meta_pop_data);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    asc_d        = asc_q;
    last_d       = last_q;
    block_d      = block_q;
    sort_valid_d = 1'b0;
    sort_asc_d   = sort_asc_q;
    sort_flat_d  = sort_flat_q;
    issue        = 1'b0;
    case (state_q)
      FILL: begin
        if (in_valid && in_ready) begin
          block_d[idx_q[2:0]] = tuple_pair_t'(in_pair);
          if (idx_q == 4'd0) asc_d = cfg_asc;
          idx_d  = idx_q + 4'd1;
          last_d = in_last;
          if (idx_q == 4'd7 || in_last) state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (inflight_q < CREDITS && !meta_full) begin
          issue        = 1'b1;
          sort_valid_d = 1'b1;
          sort_asc_d   = asc_q;
          // Unwritten slots take the pad that sorts to the tail for this direction.
          for (int i = 0; i < 8; i++) begin
            sort_flat_d[i*PAIR_WIDTH +: PAIR_WIDTH] =
              (slot_cnt_t'(i) < idx_q) ? block_q[i] : (asc_q ? PAD_ASC : PAD_DESC);
          end
          idx_d   = '0;
          last_d  = 1'b0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    slot_d     = slot_q;
    blk_pop    = 1'b0;
    out_valid  = !res_empty && !meta_empty;
    slot_final = ({1'b0, slot_q} == (meta_head.count - 4'd1));
    out_last   = out_valid && meta_head.last && slot_final;
    out_pair   = out_valid ? index_flat(res_head, slot_q) : '0;
    if (out_valid && out_ready) begin
      if (slot_final) begin
        blk_pop = 1'b1;
        slot_d  = '0;
      end else begin
        slot_d = slot_q + 3'd1;
      end
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({issue, blk_pop})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
    err_d = err_q | (sort_valid_out & res_full);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= FILL;
      idx_q        <= '0;
      asc_q        <= 1'b1;
      last_q       <= 1'b0;
      block_q      <= '{default: '0};
      sort_valid_q <= 1'b0;
      sort_asc_q   <= 1'b1;
      sort_flat_q  <= '0;
      inflight_q   <= '0;
      slot_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      asc_q        <= asc_d;
      last_q       <= last_d;
      block_q      <= block_d;
      sort_valid_q <= sort_valid_d;
      sort_asc_q   <= sort_asc_d;
      sort_flat_q  <= sort_flat_d;
      inflight_q   <= inflight_d;
      slot_q       <= slot_d;
      err_q        <= err_d;
    end
  end

`ifdef SORT_SCHED_STATS_EN
  logic [31:0] stat_blocks_q, stat_blocks_d;
  logic [31:0] stat_pads_q, stat_pads_d;

  assign stat_blocks = stat_blocks_q;
  assign stat_pads   = stat_pads_q;

  always_comb begin
    stat_blocks_d = stat_blocks_q;
    stat_pads_d   = stat_pads_q;
    if (issue) begin
      stat_blocks_d = stat_blocks_q + 32'd1;
      stat_pads_d   = stat_pads_q + 32'(4'd8 - idx_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_blocks_q <= '0;
      stat_pads_q   <= '0;
    end else begin
      stat_blocks_q <= stat_blocks_d;
      stat_pads_q   <= stat_pads_d;
    end
  end
`endif

  sched_block_fifo #(
    .WIDTH(ARR_8_FLAT_WIDTH),
    .DEPTH(RES_DEPTH)
  ) u_res_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (sort_valid_out),
    .push_data(sort_pairs_out_flat),
    .pop      (blk_pop),
    .pop_data (res_head),
    .full     (res_full),
    .empty    (res_empty)
  );

  sched_block_fifo #(
    .WIDTH(META_WIDTH),
    .DEPTH(RES_DEPTH)
  ) u_meta_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (issue),
    .push_data(meta_push_data),
    .pop      (blk_pop),
    .pop_data (meta_pop_data),
    .full     (meta_full),
    .empty    (meta_empty)
  );

endmodule
